// File: rtl/idx_gather_pkg.sv
// Shared types and helpers for the index-gather sequencer.
package idx_gather_pkg;

  localparam int unsigned IDX_AW_D = 10;
  localparam int unsigned IDX_W_D  = 16;
  localparam int unsigned AW_D     = 32;
  localparam int unsigned CALC_W   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gather_state_e;

  // Computed wide; callers truncate to their address width for modulo wrap.
  function automatic logic [CALC_W-1:0] calc_addr(input logic [CALC_W-1:0] base,
                                                  input logic [CALC_W-1:0] idx,
                                                  input logic [2:0]        shift);
    return base + (idx << shift);
  endfunction

endpackage

// File: rtl/idx_gather_ctrl_out_cnt.sv
// Saturating up/down counter of outstanding gather requests.
module idx_out_cnt #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero,
  output logic          o_full
);

  logic [CW-1:0] r_cnt;
  logic          r_zero;
  logic          r_full;
  logic          w_inc;
  logic          w_dec;
  logic [CW-1:0] w_cnt_nxt;

  // Increments at the ceiling and decrements at zero are dropped.
  always_comb begin
    w_inc     = i_inc && (r_cnt != CW'(MAX_OUT));
    w_dec     = i_dec && (r_cnt != '0);
    w_cnt_nxt = r_cnt;
    if (w_inc && !w_dec)
      w_cnt_nxt = r_cnt + CW'(1);
    else if (w_dec && !w_inc)
      w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_zero <= 1'b1;
      r_full <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_zero <= (w_cnt_nxt == '0);
      r_full <= (w_cnt_nxt == CW'(MAX_OUT));
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = r_zero;
  assign o_full = r_full;

endmodule

// File: rtl/idx_gather_ctrl.sv
// Walks a run of index-RAM entries, issuing one gather read per index.
// Optional bounds check on indices enabled by IDX_GATHER_BOUNDS_EN.
module idx_gather_ctrl
  import idx_gather_pkg::*;
#(
  parameter int unsigned IDX_AW  = IDX_AW_D,
  parameter int unsigned IDX_W   = IDX_W_D,
  parameter int unsigned AW      = AW_D,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic [IDX_AW-1:0] i_cfg_ptr,
  input  logic [IDX_AW:0]   i_cfg_count,
  input  logic [AW-1:0]     i_cfg_base,
  input  logic [2:0]        i_cfg_shift,
`ifdef IDX_GATHER_BOUNDS_EN
  input  logic [IDX_W-1:0]  i_cfg_limit,
  output logic              o_oob_err,
`endif
  output logic [IDX_AW-1:0] o_idx_raddr,
  input  logic [IDX_W-1:0]  i_idx_rdata,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic [AW-1:0]     o_req_addr,
  input  logic              i_rsp_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [IDX_AW:0]   o_issued
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  gather_state_e     r_state;
  gather_state_e     w_state_nxt;
  logic [IDX_AW-1:0] r_ptr;
  logic [IDX_AW:0]   r_rem;
  logic [IDX_AW:0]   r_issued;
  logic [AW-1:0]     r_base;
  logic [2:0]        r_shift;
  logic [CW-1:0]     w_cnt;
  logic              w_zero;
  logic              w_full;
  logic              w_skip;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_adv;
  logic              w_last;

`ifdef IDX_GATHER_BOUNDS_EN
  logic [IDX_W-1:0]  r_limit;
  logic              r_oob;
  assign w_skip    = (r_state == ISSUE) && (i_idx_rdata >= r_limit);
  assign o_oob_err = r_oob;
`else
  assign w_skip    = 1'b0;
`endif

  assign w_req_valid = (r_state == ISSUE) && !w_full && !w_skip;
  assign w_accept    = w_req_valid && i_req_ready;
  assign w_adv       = w_accept || w_skip;
  assign w_last      = (r_rem == (IDX_AW + 1)'(1));

  idx_out_cnt #(.MAX_OUT(MAX_OUT), .CW(CW)) u_out_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_inc  (w_accept),
    .i_dec  (i_rsp_valid),
    .o_cnt  (w_cnt),
    .o_zero (w_zero),
    .o_full (w_full)
  );

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start)
          w_state_nxt = (i_cfg_count == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        o_busy = 1'b1;
        if (w_adv && w_last)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        // A response landing on the final outstanding request finishes now.
        if (w_zero || ((w_cnt == CW'(1)) && i_rsp_valid))
          w_state_nxt = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Run configuration and walk pointers; ptr moves only on accept or skip.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr    <= '0;
      r_rem    <= '0;
      r_issued <= '0;
      r_base   <= '0;
      r_shift  <= '0;
`ifdef IDX_GATHER_BOUNDS_EN
      r_limit  <= '0;
      r_oob    <= 1'b0;
`endif
    end else if ((r_state == IDLE) && i_start) begin
      r_ptr    <= i_cfg_ptr;
      r_rem    <= i_cfg_count;
      r_issued <= '0;
      r_base   <= i_cfg_base;
      r_shift  <= i_cfg_shift;
`ifdef IDX_GATHER_BOUNDS_EN
      r_limit  <= i_cfg_limit;
      r_oob    <= 1'b0;
`endif
    end else if ((r_state == ISSUE) && w_adv) begin
      r_ptr <= r_ptr + IDX_AW'(1);
      r_rem <= r_rem - (IDX_AW + 1)'(1);
      if (w_accept)
        r_issued <= r_issued + (IDX_AW + 1)'(1);
`ifdef IDX_GATHER_BOUNDS_EN
      if (w_skip)
        r_oob <= 1'b1;
`endif
    end
  end

  assign o_idx_raddr = r_ptr;
  assign o_req_valid = w_req_valid;
  assign o_req_addr  = AW'(calc_addr(CALC_W'(r_base), CALC_W'(i_idx_rdata), r_shift));
  assign o_issued    = r_issued;

endmodule

// File: tb/tb_idx_gather_ctrl.sv
// Directed self-checking bench for idx_gather_ctrl (MAX_OUT=2 instance).
module tb_idx_gather_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [9:0]  cfg_ptr;
  logic [10:0] cfg_count;
  logic [31:0] cfg_base;
  logic [2:0]  cfg_shift;
  logic [9:0]  idx_raddr;
  logic [15:0] idx_rdata;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        busy;
  logic        done;
  logic [10:0] issued;
`ifdef IDX_GATHER_BOUNDS_EN
  logic [15:0] cfg_limit;
  logic        oob_err;
`endif

  logic [15:0] ram [1024];
  logic [1:0]  rsp_pipe = 2'b00;
  logic        rsp_auto;
  logic        rsp_man;
  logic [31:0] acc_addr[$];
  logic [9:0]  acc_raddr[$];
  int          done_cnt = 0;
  int          errors   = 0;
  int          checks   = 0;

  always #5 clk = ~clk;

  idx_gather_ctrl #(.IDX_AW(10), .IDX_W(16), .AW(32), .MAX_OUT(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_start     (start),
    .i_cfg_ptr   (cfg_ptr),
    .i_cfg_count (cfg_count),
    .i_cfg_base  (cfg_base),
    .i_cfg_shift (cfg_shift),
`ifdef IDX_GATHER_BOUNDS_EN
    .i_cfg_limit (cfg_limit),
    .o_oob_err   (oob_err),
`endif
    .o_idx_raddr (idx_raddr),
    .i_idx_rdata (idx_rdata),
    .o_req_valid (req_valid),
    .i_req_ready (req_ready),
    .o_req_addr  (req_addr),
    .i_rsp_valid (rsp_valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_issued    (issued)
  );

  assign idx_rdata = ram[idx_raddr];
  assign rsp_valid = rsp_pipe[1] | rsp_man;

  // Memory responder (2-cycle latency), accept log, done-pulse counter.
  always @(posedge clk) begin
    rsp_pipe <= {rsp_pipe[0], rsp_auto && req_valid && req_ready};
    if (req_valid && req_ready) begin
      acc_addr.push_back(req_addr);
      acc_raddr.push_back(idx_raddr);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_run(input logic [9:0] p, input logic [10:0] c,
                           input logic [31:0] b, input logic [2:0] s);
    cfg_ptr = p; cfg_count = c; cfg_base = b; cfg_shift = s;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, input string name);
    int k;
    k = 0;
    while ((done_cnt == base) && (k < bound)) begin cyc(1); k++; end
    checks++;
    if (done_cnt == base) begin
      errors++; $display("FAIL %s_timeout: no done within %0d cycles", name, bound);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; req_ready = 1'b0; rsp_auto = 1'b0; rsp_man = 1'b0;
    cfg_ptr = '0; cfg_count = '0; cfg_base = '0; cfg_shift = '0;
`ifdef IDX_GATHER_BOUNDS_EN
    cfg_limit = 16'hFFFF;
`endif
    cyc(3);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", req_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (issued !== 11'd0) begin errors++; $display("FAIL rst_issued got=%0d exp=0", issued); end
    checks++; if (idx_raddr !== 10'd0) begin errors++; $display("FAIL rst_raddr got=%0d exp=0", idx_raddr); end
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic;
    logic [31:0] exp [4];
    int b, d;
    exp[0] = 32'h100C; exp[1] = 32'h1000; exp[2] = 32'h101C; exp[3] = 32'h1004;
    ram[5] = 16'd3; ram[6] = 16'd0; ram[7] = 16'd7; ram[8] = 16'd1;
    req_ready = 1'b1; rsp_auto = 1'b1;
    b = acc_addr.size(); d = done_cnt;
    start_run(10'd5, 11'd4, 32'h1000, 3'd2);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid got=%b exp=1", req_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_done(d, 60, "basic");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_addr[b+i] !== exp[i]) begin
        errors++; $display("FAIL basic_addr%0d got=%h exp=%h", i, acc_addr[b+i], exp[i]);
      end
    end
    cyc(2);
    checks++; if (done_cnt - d != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d); end
    checks++; if (issued !== 11'd4) begin errors++; $display("FAIL basic_issued got=%0d exp=4", issued); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_wrap;
    logic [9:0] exp [4];
    int b, d;
    exp[0] = 10'd1022; exp[1] = 10'd1023; exp[2] = 10'd0; exp[3] = 10'd1;
    ram[1022] = 16'd2; ram[1023] = 16'd4; ram[0] = 16'd6; ram[1] = 16'd8;
    b = acc_raddr.size(); d = done_cnt;
    start_run(10'd1022, 11'd4, 32'h0, 3'd0);
    wait_done(d, 60, "wrap");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_raddr[b+i] !== exp[i]) begin
        errors++; $display("FAIL wrap_raddr%0d got=%0d exp=%0d", i, acc_raddr[b+i], exp[i]);
      end
    end
    checks++; if (acc_addr[b+2] !== 32'd6) begin errors++; $display("FAIL wrap_addr2 got=%h exp=6", acc_addr[b+2]); end
    cyc(1);
  endtask

  task automatic test_back_to_back;
    int b, d;
    ram[100] = 16'd1; ram[101] = 16'd2; ram[102] = 16'd3; ram[103] = 16'd4;
    rsp_auto = 1'b0; req_ready = 1'b1;
    b = acc_addr.size(); d = done_cnt;
    start_run(10'd100, 11'd4, 32'h0, 3'd0);
    cyc(5);
    checks++; if (acc_addr.size() - b != 2) begin errors++; $display("FAIL bp_accepts got=%0d exp=2", acc_addr.size() - b); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_valid got=%b exp=0", req_valid); end
    checks++; if (issued !== 11'd2) begin errors++; $display("FAIL bp_issued got=%0d exp=2", issued); end
    req_ready = 1'b0; rsp_man = 1'b1;
    cyc(1);
    rsp_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ((req_valid !== 1'b1) || (req_addr !== 32'd3)) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b addr=%h exp valid=1 addr=3", i, req_valid, req_addr);
      end
      cyc(1);
    end
    req_ready = 1'b1;
    cyc(1);
    checks++; if (acc_addr.size() - b != 3) begin errors++; $display("FAIL bp_one_more got=%0d exp=3", acc_addr.size() - b); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_refull_valid got=%b exp=0", req_valid); end
    rsp_man = 1'b1;
    cyc(4);
    rsp_man = 1'b0;
    wait_done(d, 20, "bp");
    checks++; if (acc_addr[b+3] !== 32'd4) begin errors++; $display("FAIL bp_last_addr got=%h exp=4", acc_addr[b+3]); end
    checks++; if (issued !== 11'd4) begin errors++; $display("FAIL bp_issued_end got=%0d exp=4", issued); end
    cyc(1);
  endtask

  task automatic test_zero_and_ignored_start;
    int b, d;
    b = acc_addr.size(); d = done_cnt;
    req_ready = 1'b1;
    start_run(10'd50, 11'd0, 32'h0, 3'd0);
    checks++; if ((done !== 1'b1) || (req_valid !== 1'b0)) begin errors++; $display("FAIL zero_done got done=%b valid=%b exp 1/0", done, req_valid); end
    cyc(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_drop got=%b exp=0", done); end
    checks++; if ((done_cnt - d != 1) || (acc_addr.size() != b)) begin errors++; $display("FAIL zero_counts got done=%0d acc=%0d exp 1/0", done_cnt - d, acc_addr.size() - b); end
    ram[200] = 16'd5; ram[201] = 16'd6; ram[202] = 16'd7;
    req_ready = 1'b0; rsp_auto = 1'b1;
    b = acc_raddr.size(); d = done_cnt;
    start_run(10'd200, 11'd3, 32'h0, 3'd0);
    cyc(2);
    start_run(10'd300, 11'd9, 32'h0, 3'd0);
    checks++; if ((idx_raddr !== 10'd200) || (issued !== 11'd0)) begin errors++; $display("FAIL ign_start got raddr=%0d issued=%0d exp 200/0", idx_raddr, issued); end
    req_ready = 1'b1;
    wait_done(d, 40, "ign");
    checks++; if (acc_raddr[b+2] !== 10'd202) begin errors++; $display("FAIL ign_raddr got=%0d exp=202", acc_raddr[b+2]); end
    checks++; if (issued !== 11'd3) begin errors++; $display("FAIL ign_issued got=%0d exp=3", issued); end
    cyc(1);
  endtask

  task automatic test_reset_mid_run;
    int b, d;
    ram[10] = 16'd1; ram[11] = 16'd2; ram[20] = 16'd9; ram[21] = 16'd8;
    rsp_auto = 1'b0; req_ready = 1'b1;
    start_run(10'd10, 11'd2, 32'h0, 3'd0);
    cyc(4);
    checks++; if ((busy !== 1'b1) || (req_valid !== 1'b0)) begin errors++; $display("FAIL mid_drain got busy=%b valid=%b exp 1/0", busy, req_valid); end
    rstn = 1'b0;
    cyc(1);
    checks++;
    if ((busy !== 1'b0) || (done !== 1'b0) || (req_valid !== 1'b0) || (issued !== 11'd0) || (idx_raddr !== 10'd0)) begin
      errors++; $display("FAIL mid_reset got busy=%b done=%b valid=%b issued=%0d raddr=%0d exp all 0", busy, done, req_valid, issued, idx_raddr);
    end
    cyc(1);
    rstn = 1'b1;
    rsp_man = 1'b1;
    cyc(3);
    rsp_man = 1'b0;
    b = acc_addr.size(); d = done_cnt;
    start_run(10'd20, 11'd2, 32'h0, 3'd0);
    cyc(4);
    checks++; if (acc_addr.size() - b != 2) begin errors++; $display("FAIL mid_new_accepts got=%0d exp=2", acc_addr.size() - b); end
    rsp_man = 1'b1;
    cyc(2);
    rsp_man = 1'b0;
    wait_done(d, 20, "mid");
    checks++; if (issued !== 11'd2) begin errors++; $display("FAIL mid_new_issued got=%0d exp=2", issued); end
    cyc(1);
  endtask

`ifdef IDX_GATHER_BOUNDS_EN
  task automatic test_bounds;
    int b, d;
    ram[30] = 16'd3; ram[31] = 16'd9; ram[32] = 16'd2;
    rsp_auto = 1'b1; req_ready = 1'b1; cfg_limit = 16'd4;
    b = acc_addr.size(); d = done_cnt;
    start_run(10'd30, 11'd3, 32'h0, 3'd0);
    wait_done(d, 40, "oob");
    checks++; if ((acc_addr.size() - b != 2) || (acc_addr[b] !== 32'd3) || (acc_addr[b+1] !== 32'd2)) begin
      errors++; $display("FAIL oob_reqs got n=%0d exp n=2 addrs 3,2", acc_addr.size() - b);
    end
    checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_err got=%b exp=1", oob_err); end
    checks++; if (issued !== 11'd2) begin errors++; $display("FAIL oob_issued got=%0d exp=2", issued); end
    cyc(1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
    test_reset;
    test_basic;
    test_wrap;
    test_back_to_back;
    test_zero_and_ignored_start;
    test_reset_mid_run;
`ifdef IDX_GATHER_BOUNDS_EN
    test_bounds;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
